regfile_param_clr: RTL
======================

Name: regfile_param_clr

Overview:
Parametrised successor to the 16x16 processor register file. It provides two asynchronous read ports and one synchronous write port, plus a dedicated CR (control register) with its own write enable and read port. New over the previous generation: parametrised width and depth, a hardwired-zero register option, write-to-read bypass, and a bulk-clear sequencer with a Busy/ClearDone handshake. It sits in the datapath between writeback and the ALU operand muxes.

Parameters:
WIDTH, 16, data width of each register and of CR
DEPTH, 16, number of general registers (2..256)
AW, $clog2(DEPTH), address width; localparam, derived, not overridable
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST_N  in  1  asynchronous active-low reset
DataIn  in  WIDTH  write data for the register file and CR
Write  in  1  register-file write enable
CRWrite  in  1  CR write enable; independent of Write
WriteAddr  in  AW  write address
ReadAddrA  in  AW  read address, port A
ReadAddrB  in  AW  read address, port B
ReadDataA  out  WIDTH  read data, port A (combinational)
ReadDataB  out  WIDTH  read data, port B (combinational)
ReadDataCR  out  WIDTH  current CR value
Clear  in  1  request to zero all general registers
Busy  out  1  high while the clear sequence runs
ClearDone  out  1  one-cycle pulse when the clear sequence completes

Behaviour:
- Reset (RST_N=0, asynchronous): all registers=0, CR=0, FSM=IDLE, clear counter=0, Busy=0, ClearDone=0. Reset mid-clear aborts the clear immediately.
- Write: on a rising edge with Write=1 and Busy=0, reg[WriteAddr] <= DataIn.
  - Dropped if ZERO_REG=1 and WriteAddr=0.
  - Dropped if WriteAddr >= DEPTH.
  - Dropped entirely while Busy=1; no queuing.
- CR: on a rising edge with CRWrite=1, CR <= DataIn. CRWrite is accepted regardless of Write, WriteAddr or Busy. ReadDataCR = CR with no bypass (new value visible the cycle after the edge). Clear does not affect CR.
- Read: ReadDataX = reg[ReadAddrX], combinational.
  - Returns 0 if ReadAddrX >= DEPTH.
  - Returns 0 if ZERO_REG=1 and ReadAddrX=0.
- Bypass (BYPASS=1): if Write=1, Busy=0, WriteAddr=ReadAddrX and the write is not dropped, ReadDataX = DataIn in the same cycle. BYPASS=0 gives the stored value until the edge. Both ports may bypass at once.
- Clear FSM states: IDLE, CLEARING, DONE.
  - IDLE -> CLEARING on a rising edge with Clear=1. Counter <= 0, Busy=1 from that edge.
  - CLEARING: each edge sets reg[counter] <= 0 and counter <= counter+1. After reg[DEPTH-1] is cleared, go to DONE. Busy is high for exactly DEPTH cycles.
  - DONE: Busy=0, ClearDone=1 for one cycle, then IDLE unconditionally.
  - Clear is ignored in CLEARING and DONE. Clear held high in IDLE after DONE starts a new sequence.
  - Busy and ClearDone are registered outputs, never both high.
- Reads during CLEARING return current array contents, which are partially cleared; this is defined behaviour.
- Simultaneous Clear=1 and Write=1 in IDLE: the write lands on that edge, then clearing starts. That register ends at 0.

Decomposition:
- Shared package regfile_pkg:
  - FSM state enum (IDLE/CLEARING/DONE, 2 bits)
  - Default WIDTH/DEPTH constants
  - CR address/role constant used by the decoder
- One sub-module, regfile_read_port, instantiated twice. It handles the address range check, the zero-register mux and the bypass compare/mux.
- Storage, write logic, CR and the clear FSM stay in the top module.

Test Plan:
- Reset, then with no writes read all addresses -> ReadDataA/B=0, ReadDataCR=0, Busy=0, ClearDone=0.
- Write DataIn=k to addr k for k=1..15, reading each on the next cycle -> ReadDataA=k. Write 16'h00FF to addr 0 (ZERO_REG=1) -> ReadDataA=0 at addr 0.
- Bypass: Write=1, WriteAddr=5, DataIn=16'hBEEF, ReadAddrA=ReadAddrB=5 -> both read 16'hBEEF before the edge. Repeat with BYPASS=0 -> old value 16'h0005 before the edge, 16'hBEEF after.
- CR: CRWrite=1, Write=0, DataIn=16'h0008 -> ReadDataCR=16'h0008 after the edge and general registers unchanged. Then CRWrite=1 while Busy -> CR updates.
- Clear with regs 1..15 loaded: pulse Clear -> Busy high for 16 cycles; a Write to addr 3 during Busy is dropped; ClearDone pulses once; all reads then return 0, CR unchanged.
- Pull RST_N low 5 cycles into a clear, then release -> Busy=0 immediately, no ClearDone pulse, all registers 0, FSM IDLE. Also run DEPTH=12, WIDTH=32: a write to addr 13 is dropped, a read of addr 13 returns 0, and Clear gives Busy for 12 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
package regfile_pkg;

   // Default geometry of the general register array.
   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_DEPTH = 16;

   // CR sits outside the addressed array and is not forwarded:
   // a CR write becomes visible only after the clock edge.
   localparam int CR_FORWARD = 0;

   // Bulk-clear sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CLEARING = 2'd1,
      ST_DONE     = 2'd2
   } clr_state_e;

   // True when an address selects an implemented general register.
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
      return (addr < depth);
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: range check, hardwired-zero mux and
// same-cycle write forwarding in front of the storage array.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int AW       = $clog2(DEPTH),
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic [WIDTH-1:0] i_mem [DEPTH],
   input  logic [AW-1:0]    i_rd_addr,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] w_rd_data;

   // Select stored data, forwarded write data or zero for this port.
   // i_wr_en is already qualified, so a dropped write is never forwarded.
   always_comb begin
      w_rd_data = '0;
      if (!addr_in_range(32'(i_rd_addr), DEPTH)) begin
         w_rd_data = '0;
      end else if ((ZERO_REG != 0) && (i_rd_addr == '0)) begin
         w_rd_data = '0;
      end else if ((BYPASS != 0) && i_wr_en && (i_wr_addr == i_rd_addr)) begin
         w_rd_data = i_wr_data;
      end else begin
         w_rd_data = i_mem[i_rd_addr];
      end
   end

   assign o_rd_data = w_rd_data;

endmodule

// File: rtl/regfile_param_clr.sv
// Parametrised register file: two combinational read ports, one write
// port, a separate control register (CR) and a bulk-clear sequencer.
module regfile_param_clr
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] DataIn,
   input  logic             Write,
   input  logic             CRWrite,
   input  logic [AW-1:0]    WriteAddr,
   input  logic [AW-1:0]    ReadAddrA,
   input  logic [AW-1:0]    ReadAddrB,
   output logic [WIDTH-1:0] ReadDataA,
   output logic [WIDTH-1:0] ReadDataB,
   output logic [WIDTH-1:0] ReadDataCR,
   input  logic             Clear,
   output logic             Busy,
   output logic             ClearDone
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_cr;
   clr_state_e       r_state;
   clr_state_e       w_state_nxt;
   logic [AW-1:0]    r_cnt;
   logic [AW-1:0]    w_cnt_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_wr_ok;
   logic             w_clr_en;

   // A write lands only when idle-side, in range and not aimed at the zero register.
   assign w_wr_ok = Write && !r_busy
                    && addr_in_range(32'(WriteAddr), DEPTH)
                    && !((ZERO_REG != 0) && (WriteAddr == '0));

   assign w_clr_en = (r_state == ST_CLEARING);

   // Clear sequencer next-state and next registered outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Clear) begin
               w_state_nxt = ST_CLEARING;
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b1;
            end else begin
               w_busy_nxt  = 1'b0;
            end
         end
         ST_CLEARING: begin
            if (32'(r_cnt) == 32'(DEPTH - 1)) begin
               w_state_nxt = ST_DONE;
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + AW'(1);
               w_busy_nxt  = 1'b1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // Clear sequencer state, counter and handshake registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Storage update: the clear sweep and host writes never overlap since
   // writes are blocked while the sweep runs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_clr_en && (r_cnt == AW'(i))) begin
               r_mem[i] <= '0;
            end else if (w_wr_ok && (WriteAddr == AW'(i))) begin
               r_mem[i] <= DataIn;
            end else begin
               r_mem[i] <= r_mem[i];
            end
         end
      end
   end

   // Control register: independent enable, unaffected by the clear sweep.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cr <= '0;
      end else if (CRWrite) begin
         r_cr <= DataIn;
      end else begin
         r_cr <= r_cr;
      end
   end

   regfile_read_port #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
   ) u_rd_a (
      .i_mem(r_mem), .i_rd_addr(ReadAddrA), .i_wr_en(w_wr_ok),
      .i_wr_addr(WriteAddr), .i_wr_data(DataIn), .o_rd_data(ReadDataA)
   );

   regfile_read_port #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
   ) u_rd_b (
      .i_mem(r_mem), .i_rd_addr(ReadAddrB), .i_wr_en(w_wr_ok),
      .i_wr_addr(WriteAddr), .i_wr_data(DataIn), .o_rd_data(ReadDataB)
   );

   assign ReadDataCR = ((CR_FORWARD != 0) && CRWrite) ? DataIn : r_cr;
   assign Busy       = r_busy;
   assign ClearDone  = r_done;

endmodule
